fft_r2_stage: RTL and testbench

- Parametrised radix-2 butterfly stage for the parallel FFT datapath.
- Takes LANES complex samples per beat and pairs lane k with lane k+STRIDE inside each group of 2*STRIDE lanes.
- Applies an optional -j twiddle to difference outputs on a beat schedule and an optional runtime /2 scaling.
- Tracks frame position so valid, sof and eof travel cycle-exact with the data; it is the generic successor to the fixed 16-lane stage wrappers.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_r2_stage_if.sv | 32 +++
 rtl/fft_r2_bfly.sv | 48 ++++
 rtl/fft_r2_stage.sv | 118 +++++++++++
 tb/tb_fft_r2_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types and arithmetic helpers for the radix-2 FFT stages.
//   cplx_t      - complex sample at the default stage output width
//   cplx_calc_t - wide working type used by the helper functions, so one
//                 helper serves any stage width up to CALC_W bits
//   rnd_half    - (v + 1) >>> 1, divide by two rounding half up
//   rot_mj      - multiply by -j: (re, im) -> (im, -re)
package fft_pkg;

  localparam int IN_W   = 14;
  localparam int OUT_W  = IN_W + 1;
  localparam int CALC_W = 32;

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [CALC_W-1:0] re;
    logic signed [CALC_W-1:0] im;
  } cplx_calc_t;

  function automatic logic signed [CALC_W-1:0] rnd_half(input logic signed [CALC_W-1:0] v);
    return (v + CALC_W'(1)) >>> 1;
  endfunction

  function automatic cplx_calc_t rot_mj(input cplx_calc_t d);
    cplx_calc_t o;
    o.re = d.im;
    o.im = -d.re;
    return o;
  endfunction

endpackage

// File: rtl/fft_r2_stage_if.sv
// fft_r2_stage_if: beat bus of the radix-2 stage.
//   din_valid/din_sof/scale_en, din_r/din_i : input beat (LANES x IN_W, signed content)
//   dout_valid/dout_sof/dout_eof, dout_r/dout_i : output beat (LANES x OUT_W, signed content)
//   frame_err : framing violation pulse, aligned with the input beat
// master drives input beats and observes results; slave is the stage.
interface fft_r2_stage_if #(
  parameter int LANES = 16,
  parameter int IN_W  = 14,
  parameter int OUT_W = IN_W + 1
);
  logic                        din_valid;
  logic                        din_sof;
  logic                        scale_en;
  logic [LANES-1:0][IN_W-1:0]  din_r;
  logic [LANES-1:0][IN_W-1:0]  din_i;
  logic                        dout_valid;
  logic                        dout_sof;
  logic                        dout_eof;
  logic [LANES-1:0][OUT_W-1:0] dout_r;
  logic [LANES-1:0][OUT_W-1:0] dout_i;
  logic                        frame_err;

  modport master (
    output din_valid, din_sof, scale_en, din_r, din_i,
    input  dout_valid, dout_sof, dout_eof, dout_r, dout_i, frame_err
  );

  modport slave (
    input  din_valid, din_sof, scale_en, din_r, din_i,
    output dout_valid, dout_sof, dout_eof, dout_r, dout_i, frame_err
  );
endinterface

// File: rtl/fft_r2_bfly.sv
// fft_r2_bfly: combinational radix-2 butterfly for one lane pair.
//   a_*, b_* : operands (IN_W signed)
//   rot      : rotate the difference by -j
//   scale    : rounded /2 on both results (after rotation)
//   s_*, d_* : a+b and (optionally rotated) a-b, OUT_W signed
module fft_r2_bfly #(
  parameter int IN_W  = 14,
  parameter int OUT_W = IN_W + 1
) (
  input  logic signed [IN_W-1:0]  a_r,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_r,
  input  logic signed [IN_W-1:0]  b_i,
  input  logic                    rot,
  input  logic                    scale,
  output logic signed [OUT_W-1:0] s_r,
  output logic signed [OUT_W-1:0] s_i,
  output logic signed [OUT_W-1:0] d_r,
  output logic signed [OUT_W-1:0] d_i
);
  import fft_pkg::*;

  cplx_calc_t sum, dif, dif_rot, sum_out, dif_out;

  // Work in the wide type: sign extension happens in the casts, so the
  // add/subtract can never overflow before the final narrowing.
  always_comb begin
    sum.re  = CALC_W'(a_r) + CALC_W'(b_r);
    sum.im  = CALC_W'(a_i) + CALC_W'(b_i);
    dif.re  = CALC_W'(a_r) - CALC_W'(b_r);
    dif.im  = CALC_W'(a_i) - CALC_W'(b_i);
    dif_rot = rot ? rot_mj(dif) : dif;
    sum_out = sum;
    dif_out = dif_rot;
    if (scale) begin
      sum_out.re = rnd_half(sum.re);
      sum_out.im = rnd_half(sum.im);
      dif_out.re = rnd_half(dif_rot.re);
      dif_out.im = rnd_half(dif_rot.im);
    end
  end

  assign s_r = OUT_W'(sum_out.re);
  assign s_i = OUT_W'(sum_out.im);
  assign d_r = OUT_W'(dif_out.re);
  assign d_i = OUT_W'(dif_out.im);

endmodule

// File: rtl/fft_r2_stage.sv
// fft_r2_stage: parametrised radix-2 butterfly stage.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : fft_r2_stage_if.slave (input beat, output beat, frame_err)
// Pairs lane k with k+STRIDE in each group of 2*STRIDE lanes, tracks the
// frame position of each beat for the -j schedule and sof/eof tags, and
// delays data and tags together by PIPE cycles (arithmetic in stage 1).
module fft_r2_stage #(
  parameter int LANES       = 16,
  parameter int STRIDE      = 8,
  parameter int IN_W        = 14,
  parameter int OUT_W       = IN_W + 1,
  parameter int PIPE        = 2,
  parameter int FRAME_BEATS = 32,
  parameter int TW_PERIOD   = 0
) (
  input logic           clk,
  input logic           rstn,
  fft_r2_stage_if.slave bus
);
  import fft_pkg::*;

  localparam int CW     = $clog2(FRAME_BEATS);
  localparam int TW_DIV = (TW_PERIOD == 0) ? 1 : TW_PERIOD;

  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_idx;
  logic          seen_sof;
  logic          is_last;
  logic          tw_rot;
  logic          tag_sof;
  logic          tag_eof;

  // A sof restarts the frame wherever the counter happens to be.
  assign beat_idx = bus.din_sof ? '0 : beat_cnt;
  assign is_last  = (beat_idx == CW'(FRAME_BEATS - 1));
  assign tag_sof  = bus.din_valid && (beat_idx == '0);
  assign tag_eof  = bus.din_valid && is_last;
  assign tw_rot   = (TW_PERIOD != 0) &&
                    (((32'(beat_idx) / 32'(TW_DIV)) % 32'd2) == 32'd1);

  // Missing sof is only an error once a frame has been started by a sof;
  // before that, beats at count 0 are silently taken as beat 0.
  assign bus.frame_err = bus.din_valid &&
                         (( bus.din_sof && (beat_cnt != '0)) ||
                          (!bus.din_sof && (beat_cnt == '0) && seen_sof));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      seen_sof <= 1'b0;
    end else if (bus.din_valid) begin
      beat_cnt <= is_last ? '0 : beat_idx + CW'(1);
      seen_sof <= seen_sof | bus.din_sof;
    end
  end

  logic [LANES-1:0][OUT_W-1:0] bf_r;
  logic [LANES-1:0][OUT_W-1:0] bf_i;

  for (genvar g = 0; g < LANES / 2; g++) begin : g_bfly
    localparam int K = (g / STRIDE) * 2 * STRIDE + (g % STRIDE);
    fft_r2_bfly #(.IN_W(IN_W), .OUT_W(OUT_W)) u_bfly (
      .a_r  (bus.din_r[K]),
      .a_i  (bus.din_i[K]),
      .b_r  (bus.din_r[K+STRIDE]),
      .b_i  (bus.din_i[K+STRIDE]),
      .rot  (tw_rot),
      .scale(bus.scale_en),
      .s_r  (bf_r[K]),
      .s_i  (bf_i[K]),
      .d_r  (bf_r[K+STRIDE]),
      .d_i  (bf_i[K+STRIDE])
    );
  end

  // Data registers load only with a valid beat so outputs hold across bubbles.
  logic [LANES-1:0][OUT_W-1:0] pr [PIPE];
  logic [LANES-1:0][OUT_W-1:0] pi [PIPE];
  logic [PIPE-1:0]             pv;
  logic [PIPE-1:0]             ps;
  logic [PIPE-1:0]             pe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      ps <= '0;
      pe <= '0;
      for (int n = 0; n < PIPE; n++) begin
        pr[n] <= '0;
        pi[n] <= '0;
      end
    end else begin
      pv[0] <= bus.din_valid;
      ps[0] <= tag_sof;
      pe[0] <= tag_eof;
      if (bus.din_valid) begin
        pr[0] <= bf_r;
        pi[0] <= bf_i;
      end
      for (int n = 1; n < PIPE; n++) begin
        pv[n] <= pv[n-1];
        ps[n] <= ps[n-1];
        pe[n] <= pe[n-1];
        if (pv[n-1]) begin
          pr[n] <= pr[n-1];
          pi[n] <= pi[n-1];
        end
      end
    end
  end

  assign bus.dout_valid = pv[PIPE-1];
  assign bus.dout_sof   = ps[PIPE-1];
  assign bus.dout_eof   = pe[PIPE-1];
  assign bus.dout_r     = pr[PIPE-1];
  assign bus.dout_i     = pi[PIPE-1];

endmodule

// File: tb/tb_fft_r2_stage.sv
// tb_fft_r2_stage: scoreboard bench for fft_r2_stage (TW_PERIOD = 8).
// The stimulus side computes each expected output beat from plain integer
// arithmetic and pushes it with its due cycle; a negedge monitor pops and
// compares whenever dout_valid is seen, and checks hold/idle otherwise.
module tb_fft_r2_stage;
  localparam int LANES  = 16;
  localparam int STRIDE = 8;
  localparam int IN_W   = 14;
  localparam int OUT_W  = 15;
  localparam int PIPE   = 2;
  localparam int FB     = 32;
  localparam int TWP    = 8;

  typedef logic [LANES-1:0][IN_W-1:0]  ivec_t;
  typedef logic [LANES-1:0][OUT_W-1:0] ovec_t;
  typedef struct {
    int    cyc;
    bit    sof;
    bit    eof;
    ovec_t r;
    ovec_t i;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_r2_stage_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fft_r2_stage #(
    .LANES(LANES), .STRIDE(STRIDE), .IN_W(IN_W), .OUT_W(OUT_W),
    .PIPE(PIPE), .FRAME_BEATS(FB), .TW_PERIOD(TWP)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  exp_t  q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    m_cnt = 0;
  bit    m_seen = 1'b0;
  ovec_t last_r = '0;
  ovec_t last_i = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input ovec_t act, input ovec_t req);
    checks++;
    if (act !== req) begin
      int bad = 0;
      failures++;
      for (int k = LANES - 1; k >= 0; k--) if (act[k] !== req[k]) bad = k;
      $display("FAIL %s lane=%0d actual=%0d required=%0d (cycle %0d)",
               nm, bad, $signed(act[bad]), $signed(req[bad]), cyc);
    end
  endtask

  function automatic int half_up(input int v);
    return (v + 1) >>> 1;  // floor((v+1)/2)
  endfunction

  function automatic void bfly_model(input ivec_t xr, input ivec_t xi, input bit rot,
                                     input bit sc, output ovec_t yr, output ovec_t yi);
    int ar, ai, br, bi, sr, si, dr, di, t;
    yr = '0;
    yi = '0;
    for (int k = 0; k < LANES; k++) begin
      if ((k % (2 * STRIDE)) < STRIDE) begin
        ar = int'($signed(xr[k]));
        ai = int'($signed(xi[k]));
        br = int'($signed(xr[k+STRIDE]));
        bi = int'($signed(xi[k+STRIDE]));
        sr = ar + br;
        si = ai + bi;
        dr = ar - br;
        di = ai - bi;
        if (rot) begin
          t  = dr;
          dr = di;
          di = -t;
        end
        if (sc) begin
          sr = half_up(sr);
          si = half_up(si);
          dr = half_up(dr);
          di = half_up(di);
        end
        yr[k]        = OUT_W'(sr);
        yi[k]        = OUT_W'(si);
        yr[k+STRIDE] = OUT_W'(dr);
        yi[k+STRIDE] = OUT_W'(di);
      end
    end
  endfunction

  function automatic ivec_t rnd_vec();
    ivec_t v;
    for (int k = 0; k < LANES; k++) v[k] = IN_W'($urandom);
    return v;
  endfunction

  task automatic drive(input bit v, input bit sof, input bit sc, input ivec_t xr, input ivec_t xi);
    int   idx;
    bit   err;
    exp_t e;
    @(posedge clk);
    #1;
    bus.din_valid = v;
    bus.din_sof   = sof;
    bus.scale_en  = sc;
    bus.din_r     = xr;
    bus.din_i     = xi;
    idx = sof ? 0 : m_cnt;
    err = v && ((sof && m_cnt != 0) || (!sof && m_cnt == 0 && m_seen));
    if (v) begin
      e.cyc = cyc + PIPE;
      e.sof = (idx == 0);
      e.eof = (idx == FB - 1);
      bfly_model(xr, xi, ((idx / TWP) % 2) == 1, sc, e.r, e.i);
      q.push_back(e);
      m_cnt  = (idx + 1) % FB;
      m_seen = m_seen | sof;
    end
    @(negedge clk);
    chk("frame_err", bus.frame_err, err);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rnd_beat(input bit sof);
    drive(1'b1, sof, 1'($urandom_range(0, 1)), rnd_vec(), rnd_vec());
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.scale_en  = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_seen = 1'b0;
    last_r = '0;
    last_i = '0;
    #1;
    chk("reset_dout_valid", bus.dout_valid, 0);
    chk("reset_dout_eof", bus.dout_eof, 0);
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.dout_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("out_cycle", cyc, mon_e.cyc);
          chk("dout_sof", bus.dout_sof, mon_e.sof);
          chk("dout_eof", bus.dout_eof, mon_e.eof);
          chk_vec("dout_r", bus.dout_r, mon_e.r);
          chk_vec("dout_i", bus.dout_i, mon_e.i);
          last_r = mon_e.r;
          last_i = mon_e.i;
        end
      end else begin
        chk("idle_sof", bus.dout_sof, 0);
        chk("idle_eof", bus.dout_eof, 0);
        chk_vec("hold_r", bus.dout_r, last_r);
        chk_vec("hold_i", bus.dout_i, last_i);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    ivec_t xr, xi;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.scale_en  = 1'b0;
    bus.din_r     = '0;
    bus.din_i     = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_sof", bus.dout_sof, 0);
    chk("rst_eof", bus.dout_eof, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk_vec("rst_r", bus.dout_r, '0);
    chk_vec("rst_i", bus.dout_i, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(10);

    // Single beat
    xr = '0; xi = '0;
    xr[0] = 14'd100;
    xr[8] = 14'd30;
    drive(1'b1, 1'b1, 1'b0, xr, xi);
    idle(2);
    chk("single_r0", $signed(bus.dout_r[0]), 130);
    chk("single_r8", $signed(bus.dout_r[8]), 70);
    chk("single_sof", bus.dout_sof, 1);

    // Twiddle: beats 0..7 unrotated, beat 8 rotated
    rnd_beat(1'b1);
    for (int b = 1; b < 8; b++) rnd_beat(1'b0);
    xr = '0; xi = '0;
    xr[0] = 14'd100;
    xr[8] = 14'd30;
    xi[8] = 14'd10;
    drive(1'b1, 1'b0, 1'b0, xr, xi);
    idle(2);
    chk("tw_r0", $signed(bus.dout_r[0]), 130);
    chk("tw_i0", $signed(bus.dout_i[0]), 10);
    chk("tw_r8", $signed(bus.dout_r[8]), -10);
    chk("tw_i8", $signed(bus.dout_i[8]), -70);

    // Scale rounding
    xr = '0; xi = '0;
    xr[0] = 14'd101;
    xi[0] = -14'sd101;
    drive(1'b1, 1'b1, 1'b1, xr, xi);
    idle(2);
    chk("scl_r0", $signed(bus.dout_r[0]), 51);
    chk("scl_i0", $signed(bus.dout_i[0]), -50);
    chk("scl_r8", $signed(bus.dout_r[8]), 51);
    chk("scl_i8", $signed(bus.dout_i[8]), -50);

    // Extremes
    xr = '0; xi = '0;
    xr[0] = -14'sd8192; xi[0] = 14'sd8191;
    xr[8] = -14'sd8192; xi[8] = 14'sd8191;
    drive(1'b1, 1'b1, 1'b0, xr, xi);
    idle(2);
    chk("ext_r0", $signed(bus.dout_r[0]), -16384);
    chk("ext_i0", $signed(bus.dout_i[0]), 16382);
    chk("ext_r8", $signed(bus.dout_r[8]), 0);
    chk("ext_i8", $signed(bus.dout_i[8]), 0);

    // Full frame with one bubble after beat 5
    for (int b = 0; b < FB; b++) begin
      rnd_beat(b == 0);
      if (b == 5) idle(1);
    end
    // Missing sof after a completed frame
    rnd_beat(1'b0);
    for (int b = 1; b < 10; b++) rnd_beat(1'b0);
    // Early sof at beat 10, then complete that frame
    rnd_beat(1'b1);
    for (int b = 1; b < FB; b++) rnd_beat(1'b0);
    // Next frame, reset during beat 4
    for (int b = 0; b < 4; b++) rnd_beat(b == 0);
    do_reset(2);
    idle(3);
    for (int b = 0; b < 5; b++) rnd_beat(1'b0);

    // Random traffic with gaps and occasional sof
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else rnd_beat($urandom_range(0, 15) == 0);
    end

    idle(PIPE + 3);
    chk("drain_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
